axis_decimator_v1_0: RTL and testbench
======================================

AXIS_DECIMATOR_V1_0 -- requirements
Module: axis_decimator_v1_0

Interface
REQ-001 SHALL have parameter inout_width, default 16, sample width (signed Q1.15 at default; passed through unmodified).
REQ-002 SHALL have parameter ratio_width, default 8, width of decimation ratio and phase counter.
REQ-003 SHALL have port aclk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port decimation_ratio  input  ratio_width  keep 1 of every N accepted samples; 0 and 1 both mean pass-through.
REQ-006 SHALL have port s_axis_tdata  input  inout_width  sample from upstream FIR.
REQ-007 SHALL have port s_axis_tlast  input  1  end-of-frame marker.
REQ-008 SHALL have port s_axis_tvalid  input  1  upstream sample valid; may be a sparse 1-cycle strobe.
REQ-009 SHALL have port s_axis_tready  output  1  block can accept a sample.
REQ-010 SHALL have port m_axis_tdata  output  inout_width  kept sample.
REQ-011 SHALL have port m_axis_tlast  output  1  end-of-frame on kept sample.
REQ-012 SHALL have port m_axis_tvalid  output  1  output sample valid.
REQ-013 SHALL have port m_axis_tready  input  1  downstream accepts.
REQ-014 SHALL have port phase_count  output  ratio_width  current phase counter value (status).

Function
REQ-015 SHALL treat an input as accepted only on a cycle with s_axis_tvalid=1 and s_axis_tready=1; SHALL ignore tdata/tlast otherwise.
REQ-016 SHALL keep an accepted sample when phase counter=0 or s_axis_tlast=1; all other accepted samples SHALL be discarded without storage.
REQ-017 SHALL, on each accepted sample: counter wraps to 0 when counter=ratio_q-1 or tlast=1; else increments by 1; ratio_q<=1 keeps counter at 0.
REQ-018 SHALL latch decimation_ratio into ratio_q only when a sample is accepted with counter=0; changes mid-group SHALL take effect at the next group start.
REQ-019 SHALL store kept samples (tdata, tlast) in a 2-entry FIFO; m_axis_* SHALL present the FIFO head.
REQ-020 SHALL drive s_axis_tready = 1 when FIFO occupancy < 2, derived from registered occupancy only (no combinational path from m_axis_tready).
REQ-021 SHALL present a kept sample on m_axis with m_axis_tvalid=1 the cycle after acceptance when FIFO is empty (latency 1 cycle).
REQ-022 SHALL pop the head on m_axis_tvalid=1 and m_axis_tready=1; m_axis_tdata/tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-023 SHALL on simultaneous push and pop keep occupancy unchanged and preserve order; sustained full rate SHALL be supported with N=1 and m_axis_tready=1.
REQ-024 SHALL never drop or duplicate a kept sample; discarded-sample acceptance SHALL not alter FIFO contents.
REQ-025 SHALL set m_axis_tlast=1 exactly on the kept sample whose input carried tlast=1.

Reset
REQ-026 SHALL, while resetn=0, asynchronously force m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0, phase_count=0, FIFO occupancy=0, ratio_q=1.
REQ-027 SHALL, from the first clock edge after resetn rises, drive s_axis_tready=1; reset mid-operation SHALL flush FIFO contents and restart grouping with the next accepted sample kept.

Verification
REQ-028 SHALL verify decimation: N=4, m_axis_tready=1, inputs 1..12 one per cycle -> outputs 1,5,9, each valid 1 cycle after its acceptance, tlast=0.
REQ-029 SHALL verify pass-through: N=0 then N=1, inputs 1..4 as 1-cycle strobes every 1000 cycles -> outputs 1,2,3,4, each 1 cycle after its strobe.
REQ-030 SHALL verify backpressure: N=1, m_axis_tready=0, offer 3,4,5 back-to-back -> s_axis_tready=0 after 2 accepts, m_axis_tdata holds 3; raise tready -> outputs 3,4,5 in order, no loss.
REQ-031 SHALL verify framing: N=4, inputs 1..9, tlast on 3 -> outputs 1, 3 (tlast=1), 4, 8; phase_count=0 after accepting 3.
REQ-032 SHALL verify ratio change: N=4, change to 2 after accepting sample 2 -> outputs 1,5,7,9 from inputs 1..9.
REQ-033 SHALL verify reset mid-operation: FIFO full (m_axis_tready=0), assert resetn=0 between edges -> m_axis_tvalid=0 immediately; after release, next output is first sample accepted post-reset.

Source files
------------

// File: rtl/axis_decimator_v1_0_if.sv
// rtl/axis_decimator_v1_0_if.sv - AXI-Stream style sample channel for the decimator
interface axis_decimator_v1_0_if #(
    parameter int inout_width = 16
);
    logic [inout_width-1:0] tdata;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_decimator_v1_0.sv
// rtl/axis_decimator_v1_0.sv - keep 1 of N accepted samples, frame-aware, 2-entry output FIFO
module axis_decimator_v1_0 #(
    parameter int inout_width = 16,
    parameter int ratio_width = 8
) (
    input  logic                    aclk,
    input  logic                    resetn,
    input  logic [ratio_width-1:0]  decimation_ratio,
    axis_decimator_v1_0_if.slave    s_axis,
    axis_decimator_v1_0_if.master   m_axis,
    output logic [ratio_width-1:0]  phase_count
);
    localparam logic [ratio_width-1:0] one = ratio_width'(1);

    logic [ratio_width-1:0] ratio_q;
    logic [ratio_width-1:0] phase;
    logic [ratio_width-1:0] eff_ratio;
    logic [ratio_width-1:0] phase_next;

    logic [inout_width-1:0] mem_data [2];
    logic [1:0]             mem_last;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             occ;
    logic [1:0]             occ_next;
    logic                   ready_q;

    logic accept;
    logic keep;
    logic pop;

    assign accept = s_axis.tvalid && ready_q;
    assign keep   = accept && ((phase == '0) || s_axis.tlast);
    assign pop    = (occ != 2'd0) && m_axis.tready;

    // A new group picks up the live ratio; mid-group samples use the latched one
    always_comb begin
        eff_ratio  = (phase == '0) ? decimation_ratio : ratio_q;
        phase_next = phase;
        if (accept) begin
            if (s_axis.tlast || (eff_ratio <= one) || (phase == eff_ratio - one)) begin
                phase_next = '0;
            end else begin
                phase_next = phase + one;
            end
        end
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        occ_next = occ + {1'b0, keep} - {1'b0, pop};
    end

    // Phase counter and group ratio latch
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            phase   <= '0;
            ratio_q <= one;
        end else if (accept) begin
            phase <= phase_next;
            if (phase == '0) begin
                ratio_q <= decimation_ratio;
            end
        end
    end

    // Two-entry FIFO; tready is registered so downstream ready never reaches upstream combinationally
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_last    <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
            ready_q     <= 1'b0;
        end else begin
            if (keep) begin
                mem_data[wr_ptr] <= s_axis.tdata;
                mem_last[wr_ptr] <= s_axis.tlast;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ     <= occ_next;
            ready_q <= (occ_next != 2'd2);
        end
    end

    assign s_axis.tready = ready_q;
    assign m_axis.tvalid = (occ != 2'd0);
    assign m_axis.tdata  = mem_data[rd_ptr];
    assign m_axis.tlast  = mem_last[rd_ptr];
    assign phase_count   = phase;
endmodule

// File: tb/tb_axis_decimator_v1_0.sv
// tb/tb_axis_decimator_v1_0.sv - self-checking bench for axis_decimator_v1_0
module tb_axis_decimator_v1_0;
    localparam int dw = 16;
    localparam int rw = 8;

    logic          aclk = 1'b0;
    logic          resetn = 1'b0;
    logic [rw-1:0] decimation_ratio;
    logic [rw-1:0] phase_count;

    axis_decimator_v1_0_if #(.inout_width(dw)) s_axis ();
    axis_decimator_v1_0_if #(.inout_width(dw)) m_axis ();

    axis_decimator_v1_0 #(.inout_width(dw), .ratio_width(rw)) dut (
        .aclk             (aclk),
        .resetn           (resetn),
        .decimation_ratio (decimation_ratio),
        .s_axis           (s_axis),
        .m_axis           (m_axis),
        .phase_count      (phase_count)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // reference model: expected kept samples in order, with acceptance cycle
    int exp_q[$];
    bit expl_q[$];
    int acc_q[$];
    int got[$];
    int want[$];
    int grp_idx = 0;
    int grp_n = 1;
    bit lat_chk = 1'b0;
    bit rand_rdy = 1'b0;
    bit prev_stall = 1'b0;
    logic [dw-1:0] prev_data = '0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // output/acceptance monitor, sampled on the falling edge
    always @(negedge aclk) begin
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            check("phase", 64'(phase_count), 64'(grp_idx));
            if (prev_stall) check("hold_data", 64'(m_axis.tdata), 64'(prev_data));
            if (m_axis.tvalid && m_axis.tready) begin
                check("out_present", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    check("out_data", 64'(m_axis.tdata), 64'(exp_q[0]));
                    check("out_last", 64'(m_axis.tlast), 64'(expl_q[0]));
                    if (lat_chk) check("latency", 64'(cyc), 64'(acc_q[0] + 1));
                    void'(exp_q.pop_front());
                    void'(expl_q.pop_front());
                    void'(acc_q.pop_front());
                end
                got.push_back(int'(m_axis.tdata));
            end
            if (s_axis.tvalid && s_axis.tready) begin
                if (grp_idx == 0) grp_n = int'(decimation_ratio);
                if (grp_idx == 0 || s_axis.tlast) begin
                    exp_q.push_back(int'(s_axis.tdata));
                    expl_q.push_back(s_axis.tlast);
                    acc_q.push_back(cyc);
                end
                if (s_axis.tlast || grp_n <= 1) grp_idx = 0;
                else grp_idx = (grp_idx + 1) % grp_n;
            end
            prev_stall = m_axis.tvalid && !m_axis.tready;
            prev_data  = m_axis.tdata;
        end
    end

    initial forever begin
        @(posedge aclk);
        #1;
        if (rand_rdy) m_axis.tready = 1'($urandom_range(0, 1));
    end

    task automatic send(input int d, input bit l);
        int n = 0;
        s_axis.tdata  = dw'(d);
        s_axis.tlast  = l;
        s_axis.tvalid = 1'b1;
        @(negedge aclk);
        while (!s_axis.tready && n < 200) begin
            n++;
            @(negedge aclk);
        end
        if (n >= 200) check("send_timeout", 64'(s_axis.tready), 64'd1);
        @(posedge aclk);
        #1;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rand_rdy = 1'b0;
        m_axis.tready = 1'b1;
        while ((exp_q.size() != 0 || m_axis.tvalid) && n < 500) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (n >= 500) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_list(input string tag);
        check({tag, "_count"}, 64'(got.size()), 64'(want.size()));
        for (int i = 0; i < want.size() && i < got.size(); i++) check(tag, 64'(got[i]), 64'(want[i]));
        got.delete();
    endtask

    task automatic clear_model();
        exp_q.delete();
        expl_q.delete();
        acc_q.delete();
        got.delete();
        grp_idx = 0;
        grp_n = 1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_model();
        repeat (2) @(posedge aclk);
        #1;
        resetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        s_axis.tdata = '0;
        s_axis.tlast = 1'b0;
        s_axis.tvalid = 1'b0;
        m_axis.tready = 1'b1;
        decimation_ratio = rw'(4);

        // reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_s_tready", 64'(s_axis.tready), 64'd0);
        check("rst_m_tvalid", 64'(m_axis.tvalid), 64'd0);
        check("rst_m_tdata", 64'(m_axis.tdata), 64'd0);
        check("rst_phase", 64'(phase_count), 64'd0);
        resetn = 1'b1;
        @(posedge aclk);
        #1;
        check("post_rst_s_tready", 64'(s_axis.tready), 64'd1);

        // decimation by 4
        lat_chk = 1'b1;
        for (int i = 1; i <= 12; i++) send(i, 1'b0);
        drain();
        want = '{1, 5, 9};
        check_list("decimate");

        // pass-through with sparse strobes, N=0 then N=1
        for (int r = 0; r <= 1; r++) begin
            decimation_ratio = rw'(r);
            for (int i = 1; i <= 4; i++) begin
                send(i, 1'b0);
                repeat (999) @(posedge aclk);
                #1;
            end
            drain();
            want = '{1, 2, 3, 4};
            check_list("passthru");
        end
        lat_chk = 1'b0;

        // backpressure
        decimation_ratio = rw'(1);
        m_axis.tready = 1'b0;
        send(3, 1'b0);
        send(4, 1'b0);
        check("bp_s_tready", 64'(s_axis.tready), 64'd0);
        repeat (3) @(posedge aclk);
        #1;
        check("bp_hold_data", 64'(m_axis.tdata), 64'd3);
        check("bp_tvalid", 64'(m_axis.tvalid), 64'd1);
        m_axis.tready = 1'b1;
        send(5, 1'b0);
        drain();
        want = '{3, 4, 5};
        check_list("backpressure");

        // framing
        decimation_ratio = rw'(4);
        for (int i = 1; i <= 9; i++) begin
            send(i, i == 3);
            if (i == 2) check("frame_phase2", 64'(phase_count), 64'd2);
            if (i == 3) check("frame_phase0", 64'(phase_count), 64'd0);
        end
        drain();
        want = '{1, 3, 4, 8};
        check_list("framing");

        // ratio change mid-group
        do_reset();
        decimation_ratio = rw'(4);
        send(1, 1'b0);
        send(2, 1'b0);
        decimation_ratio = rw'(2);
        for (int i = 3; i <= 9; i++) send(i, 1'b0);
        drain();
        want = '{1, 5, 7, 9};
        check_list("ratio_change");

        // reset mid-operation with full FIFO
        do_reset();
        decimation_ratio = rw'(1);
        m_axis.tready = 1'b0;
        send(10, 1'b0);
        send(11, 1'b1);
        check("full_s_tready", 64'(s_axis.tready), 64'd0);
        #2;
        resetn = 1'b0;
        #1;
        check("async_m_tvalid", 64'(m_axis.tvalid), 64'd0);
        check("async_m_tdata", 64'(m_axis.tdata), 64'd0);
        check("async_m_tlast", 64'(m_axis.tlast), 64'd0);
        check("async_s_tready", 64'(s_axis.tready), 64'd0);
        clear_model();
        repeat (2) @(posedge aclk);
        #1;
        resetn = 1'b1;
        @(posedge aclk);
        #1;
        check("rerst_s_tready", 64'(s_axis.tready), 64'd1);
        m_axis.tready = 1'b1;
        decimation_ratio = rw'(4);
        send(21, 1'b0);
        send(22, 1'b0);
        send(23, 1'b0);
        drain();
        want = '{21};
        check_list("after_reset");

        // randomized traffic against the model
        do_reset();
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) decimation_ratio = rw'($urandom_range(0, 5));
            send(int'($urandom_range(0, 65535)), $urandom_range(0, 5) == 0);
            repeat ($urandom_range(0, 2)) @(posedge aclk);
            #1;
        end
        drain();
        check("rand_drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
